// File: rtl/calc_pkg.sv
// ============================================================================
//  calc_pkg
//  Shared definitions for the calculator front end: operator codes, the
//  keypad scanner state encoding and the matrix-position key decoder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

  // Operator codes presented to the general controller
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_NEG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  typedef enum logic [1:0] {
    KP_SCAN     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_EMIT     = 2'd2,
    KP_RELEASE  = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_DIGIT = 2'd1,
    KIND_OP    = 2'd2,
    KIND_EQUAL = 2'd3
  } key_kind_t;

  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] value;   // digit 0-9, or operator code in [2:0]
  } key_code_t;

  // Index of the lowest active-low column; multi-key presses resolve here.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    logic [1:0] col;
    col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) col = 2'(i);
    end
    return col;
  endfunction

  // Keypad legend:  row0: 1 2 3 A   row1: 4 5 6 B
  //                 row2: 7 8 9 C   row3: * 0 # D
  function automatic key_code_t kp_decode(input logic [1:0] row,
                                          input logic [1:0] col);
    key_code_t k;
    k.kind  = KIND_NONE;
    k.value = 4'd0;
    case ({row, col})
      4'h0: begin k.kind = KIND_DIGIT; k.value = 4'd1; end
      4'h1: begin k.kind = KIND_DIGIT; k.value = 4'd2; end
      4'h2: begin k.kind = KIND_DIGIT; k.value = 4'd3; end
      4'h3: begin k.kind = KIND_OP;    k.value = {1'b0, OP_ADD}; end
      4'h4: begin k.kind = KIND_DIGIT; k.value = 4'd4; end
      4'h5: begin k.kind = KIND_DIGIT; k.value = 4'd5; end
      4'h6: begin k.kind = KIND_DIGIT; k.value = 4'd6; end
      4'h7: begin k.kind = KIND_OP;    k.value = {1'b0, OP_SUB}; end
      4'h8: begin k.kind = KIND_DIGIT; k.value = 4'd7; end
      4'h9: begin k.kind = KIND_DIGIT; k.value = 4'd8; end
      4'hA: begin k.kind = KIND_DIGIT; k.value = 4'd9; end
      4'hB: begin k.kind = KIND_OP;    k.value = {1'b0, OP_MUL}; end
      4'hC: begin k.kind = KIND_NONE;  k.value = 4'd0; end   // '*'
      4'hD: begin k.kind = KIND_DIGIT; k.value = 4'd0; end
      4'hE: begin k.kind = KIND_EQUAL; k.value = 4'd0; end   // '#'
      4'hF: begin k.kind = KIND_OP;    k.value = {1'b0, OP_NEG}; end
      default: begin k.kind = KIND_NONE; k.value = 4'd0; end
    endcase
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kp_debounce.sv
// ============================================================================
//  kp_debounce
//  Stable-cycle counter shared by the press and release phases of the
//  keypad scanner. Counts consecutive cycles with match high; done is a
//  registered flag raised once the count has reached DEBOUNCE_CYC-1.
//  Ports:
//    clk, RST  - clock, synchronous active-high reset
//    match     - current cycle is "stable"
//    clear     - restart counting (phase entry / completion consumed)
//    done      - stable long enough
//  Revision: 1.0
// ============================================================================
`default_nettype none

module kp_debounce #(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic RST,
  input  logic match,
  input  logic clear,
  output logic done
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (RST || clear || !match) begin
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= (count == LAST);
      // saturate so a long stable period cannot wrap and re-arm
      if (count != LAST) count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
//  keypad_scanner
//  Scans a 4x4 active-low matrix keypad, debounces press and release, and
//  decodes each accepted key into gencon's key-entry inputs.
//  Ports:
//    clk, RST        - clock, synchronous active-high reset
//    row_out[3:0]    - row drive, active-low one-hot
//    col_in[3:0]     - column sense, active-low
//    complete        - gencon result ready (clears equal_input)
//    keypad_input    - last digit (held)
//    read_input      - one-cycle digit strobe
//    operator_input  - operator code, one-cycle pulse
//    equal_input     - equal request level
//  Configuration macro: KEYPAD_SYNC_EN - two-flop synchronizer on col_in.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       RST,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  input  logic       complete,
  output logic [3:0] keypad_input,
  output logic       read_input,
  output logic [2:0] operator_input,
  output logic       equal_input
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    cols;
  kp_state_t     state;
  logic [DW-1:0] div_cnt;
  logic [1:0]    row_idx;
  logic [3:0]    cap_cols;
  logic          match;
  logic          clear;
  logic          done;
  logic          sample_now;
  logic          advance;
  key_code_t     code;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] col_meta;
  logic [3:0] col_sync;

  always_ff @(posedge clk) begin
    if (RST) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  assign cols = col_sync;
`else
  assign cols = col_in;
`endif

  assign sample_now = (div_cnt == DIV_LAST);
  // row_idx is frozen outside SCAN, so it still names the captured row here
  assign code = kp_decode(row_idx, lowest_low_col(cap_cols));

  always_comb begin
    match = 1'b0;
    case (state)
      KP_DEBOUNCE: match = (cols == cap_cols);
      KP_RELEASE:  match = &cols;
      default:     match = 1'b0;
    endcase
    clear   = (state == KP_SCAN) || (state == KP_EMIT) || done;
    // every return to SCAN, and an idle row period, moves on to the next row
    advance = ((state == KP_SCAN) && sample_now && (&cols)) ||
              ((state == KP_DEBOUNCE) && !done && !match) ||
              ((state == KP_RELEASE) && done);
  end

  kp_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk   (clk),
    .RST   (RST),
    .match (match),
    .clear (clear),
    .done  (done)
  );

  // Row drive and row-period divider
  always_ff @(posedge clk) begin
    if (RST) begin
      div_cnt <= '0;
      row_idx <= 2'd0;
      row_out <= 4'b1110;
    end else if (advance) begin
      div_cnt <= '0;
      row_idx <= row_idx + 1'b1;
      row_out <= {row_out[2:0], row_out[3]};
    end else if ((state == KP_SCAN) && !sample_now) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Scanner FSM with registered outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      state          <= KP_SCAN;
      cap_cols       <= 4'hF;
      keypad_input   <= 4'd0;
      read_input     <= 1'b0;
      operator_input <= OP_NONE;
      equal_input    <= 1'b0;
    end else begin
      read_input     <= 1'b0;
      operator_input <= OP_NONE;
      if (equal_input && complete) equal_input <= 1'b0;

      case (state)
        KP_SCAN: begin
          if (sample_now && !(&cols)) begin
            cap_cols <= cols;
            state    <= KP_DEBOUNCE;
          end
        end

        KP_DEBOUNCE: begin
          if (done)        state <= KP_EMIT;
          else if (!match) state <= KP_SCAN;
        end

        KP_EMIT: begin
          state <= KP_RELEASE;
          // a pending equal swallows every key until gencon completes
          if (!equal_input) begin
            case (code.kind)
              KIND_DIGIT: begin
                keypad_input <= code.value;
                read_input   <= 1'b1;
              end
              KIND_OP:    operator_input <= code.value[2:0];
              KIND_EQUAL: equal_input    <= 1'b1;
              default:    ;
            endcase
          end
        end

        KP_RELEASE: begin
          if (done) state <= KP_SCAN;
        end

        default: state <= KP_SCAN;
      endcase
    end
  end

endmodule

`default_nettype wire
